wimax_block_interleaver: RTL and testbench
==========================================

Name: wimax_block_interleaver

Overview:
- 802.16 OFDM-PHY block interleaver for the QPSK-1/2 path.
- Sits between the FEC encoder (upstream) and the QPSK modulator (downstream).
- Accepts one coded bit per cycle and writes each block of NCBPS bits into a ping-pong buffer at the permuted address mk = (NCBPS/D)*(k mod D) + floor(k/D).
- Streams each completed block out in linear order, one bit per cycle, with valid/ready flow control on both sides.

Parameters:
- NCBPS, 192, coded bits per block (interleaver block size).
- D, 16, interleaver column count; NCBPS must be a multiple of D.
- ROWS, NCBPS/D (12), derived; not overridable.

Ports:
- clk  in  1  block clock (PLL-derived in integration).
- reset_N  in  1  asynchronous active-low reset.
- in_valid  in  1  FEC bit valid.
- in_bit  in  1  FEC coded bit.
- in_ready  out  1  interleaver can accept in_bit this cycle.
- out_valid  out  1  out_bit valid.
- out_bit  out  1  interleaved bit to modulator.
- out_first  out  1  high with out_valid on bit j=0 of a block.
- out_last  out  1  high with out_valid on bit j=NCBPS-1 of a block.
- out_ready  in  1  modulator accepts out_bit this cycle.

Behaviour:
- Clocking and reset: one clock, clk. Reset is asynchronous and active-low (reset_N).
- State: two banks (0, 1) of NCBPS flops; full[1:0] flags; wr_sel; rd_sel; wr_row (0..ROWS-1); wr_col (0..D-1); rd_idx (0..NCBPS-1).
- Reset values:
  - All counters, selects, full flags and bank contents = 0.
  - in_ready=0 while reset_N=0, and 1 on the first cycle after release.
  - out_valid, out_first, out_last, out_bit = 0.
- Write side:
  - in_ready = !full[wr_sel].
  - Handshake when in_valid && in_ready: bank[wr_sel][ROWS*wr_col + wr_row] <= in_bit.
  - Then wr_col increments. On wrap (D-1 -> 0), wr_row increments.
  - When wr_row=ROWS-1 and wr_col=D-1, the block is complete: full[wr_sel]<=1, wr_sel toggles, row/col <= 0.
  - Implement the address with counters and shift/add only; no divider or modulo.
- Read side:
  - out_valid = full[rd_sel].
  - out_bit = bank[rd_sel][rd_idx].
  - out_first = out_valid && rd_idx==0.
  - out_last = out_valid && rd_idx==NCBPS-1.
  - Handshake when out_valid && out_ready: rd_idx increments. At NCBPS-1: full[rd_sel]<=0, rd_sel toggles, rd_idx<=0.
- Latency: out_valid rises the cycle after the handshake of the NCBPS-th input bit of a block.
- Throughput: with in_valid and out_ready held high, both sides sustain 1 bit/cycle indefinitely. in_ready never drops after the first block.
- Simultaneous events:
  - Read side freeing bank X and write side completing bank Y in the same cycle: both flag updates apply.
  - Write side reaching a bank freed that same cycle: in_ready sees the old flag and goes high one cycle later. This is acceptable and must be deterministic.
- Back-pressure:
  - out_ready=0 holds out_bit, rd_idx and the flags.
  - If both banks are full, in_ready=0 until one is freed.
- Reset mid-block: the partial block is discarded, no output is emitted for it, and the state returns to the reset values above.
- No bit is dropped or duplicated. in_bit is ignored when in_ready=0.

Decomposition:
- Package_wimax gains:
  - NCBPS_QPSK=192 and INTLV_D=16 constants.
  - typedef intlv_addr_t = logic [$clog2(NCBPS)-1:0].
- Sub-module wimax_intlv_addr_gen: row/col counters, mk output, block_done pulse. Reusable for the deinterleaver checker in the verify bench.

Test Plan:
- Single-one probes, block of zeros except one bit, out_ready=1:
  - one at k=0 -> out j=0 only.
  - k=1 -> j=12.
  - k=16 -> j=1.
  - k=191 -> j=191.
- Counting pattern, in_bit=k[0], 3 back-to-back blocks, ready=1 throughout:
  - in_ready stays 1 after reset release.
  - out_valid first at cycle 193 after the first handshake.
  - Each block equals the software mk permutation.
  - out_first and out_last each pulse 3 times.
- Back-pressure: out_ready=0 while 2 blocks are written:
  - in_ready drops after exactly 384 accepted bits.
  - Raising out_ready drains 384 bits in order, no loss.
- Random in_valid/out_ready toggling (50%), 20 blocks:
  - output equals the reference permutation of input.
  - out_last count = 20.
- Reset asserted after 100 bits of a block:
  - outputs go to 0 asynchronously.
  - After release, a fresh full block is interleaved correctly with no stale bits.
- Bank-swap corner: last read handshake and last write handshake in the same cycle:
  - flags update correctly.
  - next block emerges with no gap beyond one cycle.

Source files
------------

// File: rtl/wimax_block_interleaver_pkg.sv
// Shared constants and types for the 802.16 OFDM QPSK-1/2 block interleaver.
package wimax_block_interleaver_pkg;

    localparam int NCBPS_QPSK = 192;
    localparam int INTLV_D    = 16;

    typedef logic [$clog2(NCBPS_QPSK)-1:0] intlv_addr_t;

endpackage

// File: rtl/wimax_block_interleaver_if.sv
// Bit-stream handshake bundle: FEC encoder -> interleaver -> QPSK modulator.
interface wimax_block_interleaver_if;

    logic in_valid;
    logic in_bit;
    logic in_ready;
    logic out_valid;
    logic out_bit;
    logic out_first;
    logic out_last;
    logic out_ready;

    modport master (
        output in_valid, in_bit, out_ready,
        input  in_ready, out_valid, out_bit, out_first, out_last
    );

    modport slave (
        input  in_valid, in_bit, out_ready,
        output in_ready, out_valid, out_bit, out_first, out_last
    );

endinterface

// File: rtl/wimax_intlv_addr_gen.sv
// Row/column counters producing the permuted write address mk = ROWS*col + row
// without a divider; block_done pulses with the advance of the last bit of a block.
module wimax_intlv_addr_gen #(
    parameter int NCBPS = 192,
    parameter int D     = 16
) (
    input  logic                       clk,
    input  logic                       reset_N,
    input  logic                       advance,
    output logic [$clog2(NCBPS)-1:0]   mk,
    output logic                       block_done
);

    localparam int ROWS = NCBPS / D;
    localparam int AW   = $clog2(NCBPS);
    localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CW   = (D > 1) ? $clog2(D) : 1;

    logic [RW-1:0] row_reg;
    logic [CW-1:0] col_reg;
    logic [AW-1:0] base_reg;   // always equals ROWS*col_reg, kept by repeated addition
    logic          row_last;
    logic          col_last;

    assign row_last   = (row_reg == RW'(ROWS - 1));
    assign col_last   = (col_reg == CW'(D - 1));
    assign block_done = advance && row_last && col_last;
    assign mk         = base_reg + AW'(row_reg);

    always_ff @(posedge clk or negedge reset_N) begin
        if (!reset_N) begin
            row_reg  <= '0;
            col_reg  <= '0;
            base_reg <= '0;
        end else if (advance) begin
            if (col_last) begin
                col_reg  <= '0;
                base_reg <= '0;
                row_reg  <= row_last ? '0 : row_reg + 1'b1;
            end else begin
                col_reg  <= col_reg + 1'b1;
                base_reg <= base_reg + AW'(ROWS);
            end
        end
    end

endmodule

// File: rtl/wimax_block_interleaver.sv
// Ping-pong block interleaver: permuted writes into one bank while the other
// bank streams out in linear order, valid/ready on both sides.
module wimax_block_interleaver
    import wimax_block_interleaver_pkg::*;
#(
    parameter int NCBPS = NCBPS_QPSK,
    parameter int D     = INTLV_D
) (
    input  logic                         clk,
    input  logic                         reset_N,
    wimax_block_interleaver_if.slave     bus
);

    localparam int AW = $clog2(NCBPS);

    logic                  run_reg;
    logic [1:0]            full_reg;
    logic [1:0]            full_next;
    logic                  wr_sel_reg;
    logic                  rd_sel_reg;
    logic [AW-1:0]         rd_idx_reg;
    logic [AW-1:0]         mk;
    logic                  block_done;
    logic                  in_ready_w;
    logic                  out_valid_w;
    logic                  wr_fire;
    logic                  rd_fire;
    logic                  rd_last;
    logic [1:0][NCBPS-1:0] bank_q;

    // run_reg keeps in_ready low while reset is held and for the release cycle
    assign in_ready_w  = run_reg && !full_reg[wr_sel_reg];
    assign out_valid_w = full_reg[rd_sel_reg];
    assign wr_fire     = bus.in_valid && in_ready_w;
    assign rd_fire     = out_valid_w && bus.out_ready;
    assign rd_last     = (rd_idx_reg == AW'(NCBPS - 1));

    assign bus.in_ready  = in_ready_w;
    assign bus.out_valid = out_valid_w;
    assign bus.out_bit   = bank_q[rd_sel_reg][rd_idx_reg];
    assign bus.out_first = out_valid_w && (rd_idx_reg == '0);
    assign bus.out_last  = out_valid_w && rd_last;

    wimax_intlv_addr_gen #(
        .NCBPS (NCBPS),
        .D     (D)
    ) u_addr_gen (
        .clk        (clk),
        .reset_N    (reset_N),
        .advance    (wr_fire),
        .mk         (mk),
        .block_done (block_done)
    );

    // Completing and freeing always target different banks, so both may apply.
    always_comb begin
        full_next = full_reg;
        if (block_done)
            full_next[wr_sel_reg] = 1'b1;
        if (rd_fire && rd_last)
            full_next[rd_sel_reg] = 1'b0;
    end

    always_ff @(posedge clk or negedge reset_N) begin
        if (!reset_N) begin
            run_reg    <= 1'b0;
            full_reg   <= '0;
            wr_sel_reg <= 1'b0;
            rd_sel_reg <= 1'b0;
            rd_idx_reg <= '0;
        end else begin
            run_reg  <= 1'b1;
            full_reg <= full_next;
            if (block_done)
                wr_sel_reg <= ~wr_sel_reg;
            if (rd_fire) begin
                if (rd_last) begin
                    rd_idx_reg <= '0;
                    rd_sel_reg <= ~rd_sel_reg;
                end else begin
                    rd_idx_reg <= rd_idx_reg + 1'b1;
                end
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_bank
            logic [NCBPS-1:0] bank_reg;

            always_ff @(posedge clk or negedge reset_N) begin
                if (!reset_N)
                    bank_reg <= '0;
                else if (wr_fire && (wr_sel_reg == 1'(gi)))
                    bank_reg[mk] <= bus.in_bit;
            end

            assign bank_q[gi] = bank_reg;
        end
    endgenerate

endmodule

// File: tb/tb_wimax_block_interleaver.sv
// Self-checking bench: probe table, continuous, back-pressure, random and
// mid-block reset scenarios against a block-permutation reference model.
module tb_wimax_block_interleaver;
    import wimax_block_interleaver_pkg::*;

    localparam int N  = NCBPS_QPSK;
    localparam int DD = INTLV_D;
    localparam int R  = N / DD;

    logic clk = 1'b0;
    logic reset_N = 1'b0;
    always #5 clk = ~clk;

    wimax_block_interleaver_if bus();

    wimax_block_interleaver #(
        .NCBPS (N),
        .D     (DD)
    ) dut (
        .clk     (clk),
        .reset_N (reset_N),
        .bus     (bus)
    );

    int checks = 0;
    int errors = 0;

    bit in_q[$];
    bit exp_q[$];
    bit out_log[$];
    bit blk[N];
    int kcnt = 0;
    int jcnt = 0;

    int cyc, in_acc, out_cnt, first_cnt, last_cnt, ready_low;
    int first_in_cyc, first_ov_cyc, first_out_cyc, last_out_cyc;

    typedef struct {
        int k;
        int j;
    } probe_t;
    probe_t probes[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference: a completed block is permuted with bit k landing at R*(k mod D) + k/D.
    function automatic void model_push(input bit b);
        bit perm[N];
        blk[kcnt] = b;
        kcnt++;
        if (kcnt == N) begin
            for (int k = 0; k < N; k++)
                perm[R * (k % DD) + k / DD] = blk[k];
            for (int j = 0; j < N; j++)
                exp_q.push_back(perm[j]);
            kcnt = 0;
        end
    endfunction

    function automatic void model_reset();
        exp_q.delete();
        kcnt = 0;
        jcnt = 0;
    endfunction

    function automatic void clear_stats();
        cyc = 0; in_acc = 0; out_cnt = 0; first_cnt = 0; last_cnt = 0; ready_low = 0;
        first_in_cyc = -1; first_ov_cyc = -1; first_out_cyc = -1; last_out_cyc = -1;
    endfunction

    // mode 0: run max_cycles; mode 1: until out_cnt reaches target; mode 2: until in_q empty
    task automatic run(input int mode, input int target, input int pv, input int pr, input int max_cycles);
        int n = 0;
        bit done = 0;
        int pend;
        while (!done) begin
            @(negedge clk);
            bus.in_valid  = (in_q.size() > 0) && ($urandom_range(99) < pv);
            bus.in_bit    = (in_q.size() > 0) ? in_q[0] : 1'b0;
            bus.out_ready = ($urandom_range(99) < pr);
            #1;
            pend = (exp_q.size() + N - 1) / N;
            check("out_valid", bus.out_valid, exp_q.size() > 0);
            check("in_ready", bus.in_ready, pend < 2);
            if (bus.out_valid && exp_q.size() > 0) begin
                check("out_bit", bus.out_bit, exp_q[0]);
                check("out_first", bus.out_first, jcnt == 0);
                check("out_last", bus.out_last, jcnt == N - 1);
            end else if (!bus.out_valid) begin
                check("out_first_idle", bus.out_first, 0);
                check("out_last_idle", bus.out_last, 0);
            end
            if (!bus.in_ready) ready_low++;
            if (bus.out_valid && first_ov_cyc < 0) first_ov_cyc = cyc;
            if (bus.out_valid && bus.out_ready) begin
                out_cnt++;
                out_log.push_back(bus.out_bit);
                if (bus.out_first) first_cnt++;
                if (bus.out_last) last_cnt++;
                if (first_out_cyc < 0) first_out_cyc = cyc;
                last_out_cyc = cyc;
                if (exp_q.size() > 0) begin
                    void'(exp_q.pop_front());
                    jcnt = (jcnt + 1) % N;
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                if (first_in_cyc < 0) first_in_cyc = cyc;
                in_acc++;
                model_push(in_q.pop_front());
            end
            cyc++;
            n++;
            case (mode)
                0:       done = (n >= max_cycles);
                1:       done = (out_cnt >= target);
                default: done = (in_q.size() == 0);
            endcase
            if (!done && mode != 0 && n >= max_cycles) begin
                checks++;
                errors++;
                $display("FAIL run_timeout: got %0d outputs %0d inputs, expected %0d", out_cnt, in_acc, target);
                done = 1;
            end
        end
        @(posedge clk);
        #1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int pos, ones;

        probes[0] = '{k: 0,   j: 0};
        probes[1] = '{k: 1,   j: 12};
        probes[2] = '{k: 16,  j: 1};
        probes[3] = '{k: 191, j: 191};
        probes[4] = '{k: 15,  j: 180};
        probes[5] = '{k: 17,  j: 13};
        probes[6] = '{k: 176, j: 11};

        bus.in_valid  = 1'b0;
        bus.in_bit    = 1'b0;
        bus.out_ready = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", bus.in_ready, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_bit", bus.out_bit, 0);
        check("rst_out_first", bus.out_first, 0);
        check("rst_out_last", bus.out_last, 0);
        reset_N = 1'b1;
        @(posedge clk);
        #1;
        check("in_ready_after_release", bus.in_ready, 1);
        $display("reset: state checked, in_ready=%0b after release", bus.in_ready);

        // Counting pattern, three back-to-back blocks, both sides always ready
        clear_stats();
        for (int b = 0; b < 3; b++)
            for (int k = 0; k < N; k++)
                in_q.push_back(k[0]);
        run(1, 3 * N, 100, 100, 5 * N);
        check("cont_in_ready_low", ready_low, 0);
        check("cont_latency", first_ov_cyc - first_in_cyc, N);
        check("cont_no_gap", last_out_cyc - first_out_cyc, 3 * N - 1);
        check("cont_first_cnt", first_cnt, 3);
        check("cont_last_cnt", last_cnt, 3);
        $display("continuous: %0d bits out, latency %0d, span %0d", out_cnt, first_ov_cyc - first_in_cyc, last_out_cyc - first_out_cyc);

        // Single-one probes from the table
        foreach (probes[p]) begin
            clear_stats();
            out_log.delete();
            for (int k = 0; k < N; k++)
                in_q.push_back(k == probes[p].k);
            run(1, N, 100, 100, 3 * N);
            pos = -1;
            ones = 0;
            foreach (out_log[i]) begin
                if (out_log[i]) begin
                    ones++;
                    if (pos < 0) pos = i;
                end
            end
            check("probe_pos", pos, probes[p].j);
            check("probe_ones", ones, 1);
            $display("probe: one at k=%0d emerged at j=%0d (table j=%0d)", probes[p].k, pos, probes[p].j);
        end

        // Back-pressure: two blocks fill both banks, then drain
        clear_stats();
        for (int i = 0; i < 3 * N; i++)
            in_q.push_back(1'($urandom_range(1)));
        run(0, 0, 100, 0, 2 * N + 40);
        check("bp_accepted", in_acc, 2 * N);
        check("bp_in_ready", bus.in_ready, 0);
        run(1, 3 * N, 100, 100, 8 * N);
        check("bp_total_in", in_acc, 3 * N);
        check("bp_total_out", out_cnt, 3 * N);
        $display("backpressure: %0d accepted before stall, %0d drained", 2 * N, out_cnt);

        // Random handshakes on both sides, 20 blocks
        clear_stats();
        for (int i = 0; i < 20 * N; i++)
            in_q.push_back(1'($urandom_range(1)));
        run(1, 20 * N, 50, 50, 40000);
        check("rand_last_cnt", last_cnt, 20);
        check("rand_first_cnt", first_cnt, 20);
        $display("random: %0d bits out over %0d cycles", out_cnt, cyc);

        // Reset with one full bank presenting and 100 bits of the next block written
        clear_stats();
        for (int i = 0; i < N; i++)
            in_q.push_back(1'b1);
        for (int i = 0; i < 100; i++)
            in_q.push_back(1'($urandom_range(1)));
        run(2, 0, 100, 0, 3 * N);
        check("rst_mid_accepted", in_acc, N + 100);
        check("pre_reset_out_valid", bus.out_valid, 1);
        check("pre_reset_out_bit", bus.out_bit, 1);
        #2;
        reset_N = 1'b0;
        #1;
        check("async_out_valid", bus.out_valid, 0);
        check("async_out_bit", bus.out_bit, 0);
        check("async_out_first", bus.out_first, 0);
        check("async_in_ready", bus.in_ready, 0);
        model_reset();
        in_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("mid_rst_in_ready", bus.in_ready, 0);
        check("mid_rst_out_last", bus.out_last, 0);
        reset_N = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rst_release_ready", bus.in_ready, 1);
        clear_stats();
        out_log.delete();
        for (int i = 0; i < N; i++)
            in_q.push_back(1'($urandom_range(1)));
        run(1, N, 100, 100, 3 * N);
        run(0, 0, 0, 100, 20);
        check("post_rst_out_cnt", out_cnt, N);
        $display("midblock reset: fresh block of %0d bits interleaved", out_cnt);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
